id_hazard_ctrl: RTL and testbench
=================================

Name: id_hazard_ctrl

Overview:
Registered decode-stage control unit for the DLX pipeline.
- Decodes the ID-stage instruction and owns the ID/EX control register.
- Detects load-use hazards and sequences multi-cycle multiplies.
- Squashes wrong-path instructions after a taken branch or jump.
- Sits between the IF/ID register and EX. It replaces the purely combinational decode path with stall, flush and bubble generation.

Parameters:
MUL_CYCLES, 4, EX occupancy of a multiply in cycles (>=1)
FLUSH_SLOTS, 1, valid ID instructions squashed per flush (>=1)
CNT_W, 16, width of saturating stall-cycle counter

Ports:
clk  in  1  clock
rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
id_instr  in  32  ID instruction, bit 0 = MSB; opcode [0:5], rs1 [6:10], rs2 [11:15], rd [16:20], func [26:31]
id_valid  in  1  id_instr is a real instruction
flush_i  in  1  taken branch/jump resolved in EX this cycle
ex_valid  out  1  ID/EX holds a live instruction
ex_reg_write  out  1  writes integer RF
ex_mem_to_reg  out  1  load
ex_mem_write  out  1  store
ex_branch  out  1  BEQZ/BNEZ
ex_jump  out  1  J/JAL/JR/JALR
ex_mul  out  1  multiply
ex_fp_reg_write  out  1  writes FP RF
ex_rd  out  5  integer destination register
stall_o  out  1  hold PC and IF/ID this cycle
mem_bubble_o  out  1  EX/MEM must capture a bubble this cycle
mul_busy_o  out  1  FSM in MUL_BUSY
stall_cnt  out  CNT_W  stall cycles since reset, saturating

Behaviour:
Reset:
- All outputs 0, FSM = RUN, counters 0.
- Reset is asynchronous at any point, including mid-multiply or mid-flush: FSM returns to RUN and ex_valid = 0.

Decode (combinational on id_instr; all-zero word = NOP, no effects):
- Loads: opcode 0x20-0x25.
- Stores: 0x28-0x2B.
- Branches: 0x04/0x05.
- J/JAL: 0x02/0x03. JR/JALR: 0x12/0x13.
- R-type: opcode 0x00.
- Multiply: opcode 0x01 with func[27:31] = 0x0E or 0x16.
- MOVI2FP: R-type func 0x35; sets fp_reg_write, clears reg_write.
- MOVFP2I: R-type func 0x34; sets reg_write.
- reg_write: set for everything except stores, branches, J, JR, MOVI2FP and NOP.
- Destination register: R-type -> rd; I-type -> rs2 field; JAL/JALR -> 31.
- Source registers: rs1 is used by all except J/JAL. rs2 is used by R-type and stores.

Load-use hazard:
- Condition: ex_valid & ex_mem_to_reg & ex_rd != 0 & id_valid, and ex_rd equals a used source of id_instr.
- Response: stall_o = 1 and the ID/EX register loads a bubble (ex_valid = 0, all control 0).
- Lasts exactly 1 cycle.

FSM states:
RUN:
- Normal operation; ID/EX loads decode when id_valid and there is no stall.
- A multiply entering ID/EX loads mul_cnt = MUL_CYCLES-1.
- If MUL_CYCLES > 1, go to MUL_BUSY.
MUL_BUSY:
- ID/EX holds its contents.
- stall_o = 1, mem_bubble_o = 1, mul_busy_o = 1; mul_cnt decrements each cycle.
- When mul_cnt reaches 1, return to RUN next edge. On that final cycle mem_bubble_o = 0, so EX/MEM captures the product.
- Total EX occupancy is exactly MUL_CYCLES cycles.
FLUSH:
- Entered from RUN when flush_i = 1.
- In the flush cycle, the ID/EX register loads a bubble.
- flush_left = FLUSH_SLOTS-1. Each subsequent valid ID instruction becomes a bubble and decrements flush_left; invalid cycles do not count.
- Return to RUN when flush_left = 0. FLUSH_SLOTS = 1 means a single-cycle squash with no FLUSH residency.

Priority and boundary conditions:
- flush_i has priority over a load-use stall in the same cycle: no stall, bubble only.
- flush_i in MUL_BUSY cannot occur legally; it is ignored and flagged by a bench assertion.
- A load-use hazard on a multiply in ID stalls first; the multiply then issues normally.

Stall counter:
- stall_cnt increments on every cycle with stall_o = 1.
- It holds at 2^CNT_W-1 and never wraps.

Test Plan:
1. LW r3 (0x8C030000) in EX, then ADD r5,r3,r4 in ID -> stall_o = 1 for 1 cycle; ex_valid = 0 that cycle; ADD issues next cycle; stall_cnt = 1.
2. Same as 1 but ADD r5,r0,r4 after LW r0, and separately ADDI r3,r6,#1 after LW r7 -> no stall in either case.
3. MUL_CYCLES = 4: multiply issued -> mul_busy_o = 1 for 3 cycles, stall_o = 1 for 3 cycles, mem_bubble_o = 1 for the first 2 of them then 0; stall_cnt = 3.
4. FLUSH_SLOTS = 2: flush_i pulse, then id_valid low 1 cycle, then 2 valid instructions -> first valid instruction squashed, second issues; ex_valid = 0 for 3 cycles.
5. flush_i and load-use hazard in the same cycle -> stall_o = 0, ID/EX bubble.
6. rst_n asserted in the 2nd MUL_BUSY cycle -> all outputs 0 asynchronously; after release, the FSM is in RUN and the next instruction issues with no residual stall. Also CNT_W = 2 with 5 stalls -> stall_cnt = 3.

Source files
------------

// File: rtl/id_hazard_ctrl.sv
// id_hazard_ctrl: DLX decode stage owning the ID/EX control register, with
// load-use stall, multi-cycle multiply sequencing and wrong-path squash.
module id_hazard_ctrl #(
  parameter int MUL_CYCLES  = 4,
  parameter int FLUSH_SLOTS = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      id_instr,
  input  logic             id_valid,
  input  logic             flush_i,
  output logic             ex_valid,
  output logic             ex_reg_write,
  output logic             ex_mem_to_reg,
  output logic             ex_mem_write,
  output logic             ex_branch,
  output logic             ex_jump,
  output logic             ex_mul,
  output logic             ex_fp_reg_write,
  output logic [4:0]       ex_rd,
  output logic             stall_o,
  output logic             mem_bubble_o,
  output logic             mul_busy_o,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam int MW = $clog2(MUL_CYCLES + 1);
  localparam int FW = $clog2(FLUSH_SLOTS + 1);

  typedef enum logic [1:0] {RUN, MUL_BUSY, FLUSH} state_t;

  state_t           state_q, state_d;
  logic [MW-1:0]    mul_cnt_q, mul_cnt_d;
  logic [FW-1:0]    flush_left_q, flush_left_d;
  logic [12:0]      ex_q, ex_d, dec;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [5:0]       op, fn;
  logic [4:0]       rs1, rs2, dest;
  logic             is_load, is_store, is_br, is_j, is_jr, is_r, is_mul, is_i2f, is_nop;
  logic             reg_w, hazard;

  // DLX numbers bits MSB-first, so opcode [0:5] is id_instr[31:26]
  assign op       = id_instr[31:26];
  assign rs1      = id_instr[25:21];
  assign rs2      = id_instr[20:16];
  assign fn       = id_instr[5:0];
  assign is_load  = (op >= 6'h20) && (op <= 6'h25);
  assign is_store = (op >= 6'h28) && (op <= 6'h2b);
  assign is_br    = op[5:1] == 5'b00010;
  assign is_j     = op[5:1] == 5'b00001;
  assign is_jr    = op[5:1] == 5'b01001;
  assign is_r     = op == 6'h00;
  assign is_mul   = (op == 6'h01) && ((fn[4:0] == 5'h0e) || (fn[4:0] == 5'h16));
  assign is_i2f   = is_r && (fn == 6'h35);
  assign is_nop   = id_instr == 32'd0;
  assign reg_w    = !(is_store || is_br || op == 6'h02 || op == 6'h12 || is_i2f || is_nop);
  assign dest     = (op == 6'h03 || op == 6'h13) ? 5'd31 : is_r ? id_instr[15:11] : rs2;
  assign dec      = {1'b1, reg_w, is_load, is_store, is_br, is_j | is_jr, is_mul, is_i2f,
                     reg_w ? dest : 5'd0};
  assign hazard   = ex_valid && ex_mem_to_reg && (ex_rd != 5'd0) && id_valid &&
                    ((!is_j && (rs1 == ex_rd)) || ((is_r || is_store) && (rs2 == ex_rd)));

  assign {ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_write, ex_branch, ex_jump, ex_mul,
          ex_fp_reg_write, ex_rd} = ex_q;
  assign stall_cnt = stall_cnt_q;

  always_comb begin
    state_d      = state_q;
    mul_cnt_d    = mul_cnt_q;
    flush_left_d = flush_left_q;
    ex_d         = '0;
    stall_o      = 1'b0;
    mem_bubble_o = 1'b0;
    mul_busy_o   = 1'b0;
    if (state_q == MUL_BUSY) begin
      ex_d         = ex_q;
      stall_o      = 1'b1;
      mul_busy_o   = 1'b1;
      mem_bubble_o = mul_cnt_q != MW'(1);
      mul_cnt_d    = mul_cnt_q - MW'(1);
      if (mul_cnt_q == MW'(1)) state_d = RUN;
    end else if (state_q == FLUSH) begin
      if (id_valid) begin
        flush_left_d = flush_left_q - FW'(1);
        if (flush_left_q == FW'(1)) state_d = RUN;
      end
    end else if (flush_i) begin
      flush_left_d = FW'(FLUSH_SLOTS - 1);
      if (FLUSH_SLOTS > 1) state_d = FLUSH;
    end else if (hazard) begin
      stall_o = 1'b1;
    end else if (id_valid) begin
      ex_d = dec;
      if (is_mul) begin
        mul_cnt_d = MW'(MUL_CYCLES - 1);
        if (MUL_CYCLES > 1) state_d = MUL_BUSY;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      mul_cnt_q    <= '0;
      flush_left_q <= '0;
      ex_q         <= '0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      mul_cnt_q    <= mul_cnt_d;
      flush_left_q <= flush_left_d;
      ex_q         <= ex_d;
      stall_cnt_q  <= (stall_o && stall_cnt_q != '1) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    end
  end
endmodule

// File: tb/tb_id_hazard_ctrl.sv
// tb_id_hazard_ctrl: directed and randomized checks of id_hazard_ctrl in two
// configurations (MUL 4 / FLUSH 2 / CNT 16 and MUL 1 / FLUSH 1 / CNT 2).
module tb_id_hazard_ctrl;
  typedef struct packed {
    logic v, rw, m2r, mw, br, jp, mul, fpw;
    logic [4:0] rd;
  } ctl_t;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [31:0] id_instr = '0;
  logic        id_valid = 1'b0, flush_i = 1'b0;
  wire  [12:0] ex0, ex1;
  wire         st0, mb0, bu0, st1, mb1, bu1;
  wire  [15:0] cnt0;
  wire  [1:0]  cnt1;
  int          tests = 0, fails = 0;

  ctl_t mx [2];
  int   mbusy [2], msq [2], mcnt [2];
  int   MC [2]   = '{4, 1};
  int   FS [2]   = '{2, 1};
  int   CMAX [2] = '{65535, 3};

  always #5 clk = ~clk;

  id_hazard_ctrl #(.MUL_CYCLES(4), .FLUSH_SLOTS(2), .CNT_W(16)) u0 (
    .clk(clk), .rst_n(rst_n), .id_instr(id_instr), .id_valid(id_valid), .flush_i(flush_i),
    .ex_valid(ex0[12]), .ex_reg_write(ex0[11]), .ex_mem_to_reg(ex0[10]), .ex_mem_write(ex0[9]),
    .ex_branch(ex0[8]), .ex_jump(ex0[7]), .ex_mul(ex0[6]), .ex_fp_reg_write(ex0[5]),
    .ex_rd(ex0[4:0]), .stall_o(st0), .mem_bubble_o(mb0), .mul_busy_o(bu0), .stall_cnt(cnt0));

  id_hazard_ctrl #(.MUL_CYCLES(1), .FLUSH_SLOTS(1), .CNT_W(2)) u1 (
    .clk(clk), .rst_n(rst_n), .id_instr(id_instr), .id_valid(id_valid), .flush_i(flush_i),
    .ex_valid(ex1[12]), .ex_reg_write(ex1[11]), .ex_mem_to_reg(ex1[10]), .ex_mem_write(ex1[9]),
    .ex_branch(ex1[8]), .ex_jump(ex1[7]), .ex_mul(ex1[6]), .ex_fp_reg_write(ex1[5]),
    .ex_rd(ex1[4:0]), .stall_o(st1), .mem_bubble_o(mb1), .mul_busy_o(bu1), .stall_cnt(cnt1));

  // A taken branch can never resolve while a multiply owns EX
  always @(posedge clk)
    if (rst_n) assert (!(bu0 && flush_i)) else $error("FAIL flush_in_mul_busy: flush_i=1 while mul_busy_o=1");

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [31:0] rt(int s1, int s2, int d, int f);
    return {6'h00, 5'(s1), 5'(s2), 5'(d), 5'd0, 6'(f)};
  endfunction

  function automatic logic [31:0] it(int o, int s1, int s2, int imm);
    return {6'(o), 5'(s1), 5'(s2), 16'(imm)};
  endfunction

  function automatic ctl_t dec(input logic [31:0] w);
    logic [5:0] o = w[31:26];
    ctl_t d = '0;
    logic i2f, wr;
    logic [4:0] dst;
    d.v = 1'b1;
    if (w == 32'd0) return d;
    i2f   = (o == 6'h00) && (w[5:0] == 6'h35);
    wr    = !(o inside {[6'h28:6'h2B], 6'h04, 6'h05, 6'h02, 6'h12}) && !i2f;
    dst   = (o == 6'h03 || o == 6'h13) ? 5'd31 : (o == 6'h00) ? w[15:11] : w[20:16];
    d.rw  = wr;
    d.m2r = o inside {[6'h20:6'h25]};
    d.mw  = o inside {[6'h28:6'h2B]};
    d.br  = o inside {6'h04, 6'h05};
    d.jp  = o inside {6'h02, 6'h03, 6'h12, 6'h13};
    d.mul = (o == 6'h01) && (w[4:0] inside {5'h0E, 5'h16});
    d.fpw = i2f;
    d.rd  = wr ? dst : 5'd0;
    return d;
  endfunction

  function automatic bit hz(int c);
    ctl_t e = mx[c];
    logic [5:0] o = id_instr[31:26];
    bit u1 = !(o inside {6'h02, 6'h03});
    bit u2 = (o == 6'h00) || (o inside {[6'h28:6'h2B]});
    return e.v && e.m2r && e.rd != 0 && id_valid &&
           ((u1 && id_instr[25:21] == e.rd) || (u2 && id_instr[20:16] == e.rd));
  endfunction

  function automatic bit exp_st(int c);
    return mbusy[c] > 0 || (msq[c] == 0 && !flush_i && hz(c));
  endfunction

  task automatic model_step();
    for (int c = 0; c < 2; c++) begin
      if (!rst_n) begin
        mx[c] = '0; mbusy[c] = 0; msq[c] = 0; mcnt[c] = 0;
      end else if (mbusy[c] > 0) begin
        mbusy[c]--;
        if (mcnt[c] < CMAX[c]) mcnt[c]++;
      end else if (msq[c] > 0) begin
        mx[c] = '0;
        if (id_valid) msq[c]--;
      end else if (flush_i) begin
        mx[c] = '0;
        msq[c] = FS[c] - 1;
      end else if (hz(c)) begin
        mx[c] = '0;
        if (mcnt[c] < CMAX[c]) mcnt[c]++;
      end else begin
        mx[c] = id_valid ? dec(id_instr) : '0;
        if (id_valid && mx[c].mul) mbusy[c] = MC[c] - 1;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; id_valid = 1'b0; flush_i = 1'b0; id_instr = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    tests++;
    if ({ex0, st0, mb0, bu0, cnt0} !== 32'd0) begin
      fails++; $display("FAIL reset_u0: outputs=%h expected 0", {ex0, st0, mb0, bu0, cnt0});
    end
    tests++;
    if ({ex1, st1, mb1, bu1, cnt1} !== 18'd0) begin
      fails++; $display("FAIL reset_u1: outputs=%h expected 0", {ex1, st1, mb1, bu1, cnt1});
    end
  endtask

  task automatic test_load_use();
    apply_reset();
    id_instr = 32'h8C030000; id_valid = 1'b1; #1; tick();
    id_instr = rt(3, 4, 5, 'h20); #1;
    tests++;
    if (st0 !== 1'b1) begin fails++; $display("FAIL lu_stall: stall_o=%b expected 1", st0); end
    tick(); #1;
    tests++;
    if ({ex0[12], st0} !== 2'b00) begin
      fails++; $display("FAIL lu_bubble: ex_valid,stall_o=%b expected 00", {ex0[12], st0});
    end
    tick(); #1;
    tests++;
    if ({ex0[12:11], ex0[4:0], cnt0} !== {2'b11, 5'd5, 16'd1}) begin
      fails++; $display("FAIL lu_issue: valid,rw,rd,cnt=%b,%0d,%0d expected 11,5,1", ex0[12:11], ex0[4:0], cnt0);
    end
  endtask

  task automatic test_no_stall();
    apply_reset();
    id_instr = it('h23, 0, 0, 0); id_valid = 1'b1; #1; tick();
    id_instr = rt(0, 4, 5, 'h20); #1;
    tests++;
    if (st0 !== 1'b0) begin fails++; $display("FAIL lu_r0: stall_o=%b expected 0", st0); end
    tick();
    id_instr = it('h23, 0, 7, 0); #1; tick();
    id_instr = it('h08, 6, 3, 1); #1;
    tests++;
    if (st0 !== 1'b0) begin fails++; $display("FAIL lu_other_reg: stall_o=%b expected 0", st0); end
    tick();
    id_instr = 32'h8C030000; #1; tick();
    id_instr = it('h08, 6, 3, 1); #1;
    tests++;
    if (st0 !== 1'b0) begin fails++; $display("FAIL itype_rs2_not_src: stall_o=%b expected 0", st0); end
    tick(); #1;
    tests++;
    if (cnt0 !== 16'd0) begin fails++; $display("FAIL no_stall_cnt: stall_cnt=%0d expected 0", cnt0); end
  endtask

  task automatic test_mul();
    apply_reset();
    id_instr = {6'h01, 5'd1, 5'd2, 5'd3, 5'd0, 6'h0E}; id_valid = 1'b1; #1;
    tests++;
    if (st0 !== 1'b0) begin fails++; $display("FAIL mul_issue_stall: stall_o=%b expected 0", st0); end
    tick();
    id_instr = rt(3, 4, 5, 'h20);
    for (int k = 0; k < 3; k++) begin
      #1;
      tests++;
      if ({bu0, st0, mb0, ex0[6]} !== {1'b1, 1'b1, k < 2, 1'b1}) begin
        fails++; $display("FAIL mul_busy_%0d: busy,stall,bubble,mul=%b expected 11%0d1", k, {bu0, st0, mb0, ex0[6]}, k < 2);
      end
      tick();
    end
    #1;
    tests++;
    if ({bu0, st0, ex0[6], cnt0} !== {3'b001, 16'd3}) begin
      fails++; $display("FAIL mul_done: busy,stall,mul=%b cnt=%0d expected 001 cnt=3", {bu0, st0, ex0[6]}, cnt0);
    end
    tick(); #1;
    tests++;
    if ({ex0[6], ex0[4:0]} !== {1'b0, 5'd5}) begin
      fails++; $display("FAIL mul_next: mul=%b rd=%0d expected 0 rd=5", ex0[6], ex0[4:0]);
    end
  endtask

  task automatic test_flush();
    apply_reset();
    id_instr = rt(1, 2, 6, 'h20); id_valid = 1'b1; #1; tick();
    flush_i = 1'b1; id_instr = rt(1, 2, 7, 'h20); #1;
    tests++;
    if (st0 !== 1'b0) begin fails++; $display("FAIL flush_stall: stall_o=%b expected 0", st0); end
    tick();
    flush_i = 1'b0; id_valid = 1'b0; #1;
    tests++;
    if (ex0[12] !== 1'b0) begin fails++; $display("FAIL flush_bubble: ex_valid=%b expected 0", ex0[12]); end
    tick();
    id_valid = 1'b1; id_instr = rt(1, 2, 8, 'h20); #1;
    tests++;
    if (ex0[12] !== 1'b0) begin fails++; $display("FAIL flush_idle: ex_valid=%b expected 0", ex0[12]); end
    tick();
    id_instr = rt(1, 2, 5, 'h20); #1;
    tests++;
    if (ex0[12] !== 1'b0) begin fails++; $display("FAIL flush_squash: ex_valid=%b expected 0", ex0[12]); end
    tick(); #1;
    tests++;
    if ({ex0[12], ex0[4:0]} !== {1'b1, 5'd5}) begin
      fails++; $display("FAIL flush_resume: valid=%b rd=%0d expected 1 rd=5", ex0[12], ex0[4:0]);
    end
  endtask

  task automatic test_flush_vs_stall();
    apply_reset();
    id_instr = 32'h8C030000; id_valid = 1'b1; #1; tick();
    id_instr = rt(3, 4, 5, 'h20); flush_i = 1'b1; #1;
    tests++;
    if (st0 !== 1'b0) begin fails++; $display("FAIL flush_over_stall: stall_o=%b expected 0", st0); end
    tick();
    flush_i = 1'b0; #1;
    tests++;
    if ({ex0, cnt0} !== 29'd0) begin
      fails++; $display("FAIL flush_over_stall_bubble: ex=%h cnt=%0d expected 0,0", ex0, cnt0);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    id_instr = {6'h01, 5'd1, 5'd2, 5'd3, 5'd0, 6'h16}; id_valid = 1'b1; #1; tick();
    id_instr = rt(1, 2, 5, 'h20); #1; tick(); #1;
    tests++;
    if (bu0 !== 1'b1) begin fails++; $display("FAIL pre_reset_busy: mul_busy_o=%b expected 1", bu0); end
    rst_n = 1'b0; #1;
    tests++;
    if ({ex0, st0, mb0, bu0, cnt0} !== 32'd0) begin
      fails++; $display("FAIL async_reset: outputs=%h expected 0", {ex0, st0, mb0, bu0, cnt0});
    end
    tick();
    rst_n = 1'b1; #1;
    tests++;
    if ({st0, bu0} !== 2'b00) begin fails++; $display("FAIL post_reset_run: stall,busy=%b expected 00", {st0, bu0}); end
    tick(); #1;
    tests++;
    if ({ex0[12], ex0[4:0], st0} !== {1'b1, 5'd5, 1'b0}) begin
      fails++; $display("FAIL post_reset_issue: valid=%b rd=%0d stall=%b expected 1,5,0", ex0[12], ex0[4:0], st0);
    end
  endtask

  task automatic test_saturate();
    apply_reset();
    id_valid = 1'b1;
    repeat (5) begin
      id_instr = 32'h8C030000; #1; tick();
      id_instr = rt(3, 4, 5, 'h20); #1; tick();
      tick();
    end
    tests++;
    if (cnt1 !== 2'd3) begin fails++; $display("FAIL sat_cnt2: stall_cnt=%0d expected 3", cnt1); end
    tests++;
    if (cnt0 !== 16'd5) begin fails++; $display("FAIL sat_cnt16: stall_cnt=%0d expected 5", cnt0); end
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [5:0] ops [14] = '{6'h00, 6'h00, 6'h01, 6'h23, 6'h20, 6'h25, 6'h2B, 6'h28,
                             6'h08, 6'h04, 6'h05, 6'h02, 6'h03, 6'h12};
    logic [5:0] rf [5] = '{6'h20, 6'h22, 6'h34, 6'h35, 6'h24};
    logic [5:0] mf [4] = '{6'h0E, 6'h16, 6'h2E, 6'h05};
    logic [5:0] o, f;
    if ($urandom_range(0, 15) == 0) return 32'd0;
    o = ($urandom_range(0, 14) == 14) ? 6'h13 : ops[$urandom_range(0, 13)];
    f = (o == 6'h00) ? rf[$urandom_range(0, 4)] : (o == 6'h01) ? mf[$urandom_range(0, 3)] : 6'($urandom);
    return {o, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'd0, f};
  endfunction

  task automatic test_random();
    logic [31:0] e0;
    logic [17:0] e1;
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      id_valid = $urandom_range(0, 9) < 8;
      id_instr = rnd_instr();
      flush_i  = (mbusy[0] == 0) && ($urandom_range(0, 9) == 0);
      #1;
      e0 = {mx[0], exp_st(0), mbusy[0] > 1, mbusy[0] > 0, 16'(mcnt[0])};
      e1 = {mx[1], exp_st(1), mbusy[1] > 1, mbusy[1] > 0, 2'(mcnt[1])};
      tests++;
      if ({ex0, st0, mb0, bu0, cnt0} !== e0) begin
        fails++; $display("FAIL rand_u0 cycle %0d: got %h expected %h", i, {ex0, st0, mb0, bu0, cnt0}, e0);
      end
      tests++;
      if ({ex1, st1, mb1, bu1, cnt1} !== e1) begin
        fails++; $display("FAIL rand_u1 cycle %0d: got %h expected %h", i, {ex1, st1, mb1, bu1, cnt1}, e1);
      end
      tick();
    end
    flush_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_stall();
    test_mul();
    test_flush();
    test_flush_vs_stall();
    test_async_reset();
    test_saturate();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
